// File: rtl/sobel_pkg.sv
// Shared types and the Sobel magnitude arithmetic for the streaming edge stage.
package sobel_pkg;

    typedef logic [7:0]          pixel_t;
    typedef logic signed [10:0]  grad_t;
    typedef logic [11:0]         mag_t;

    // 3x3 window indexed w[y][x]: y=0 is the top (oldest) row, x=0 the leftmost (oldest) column.
    typedef pixel_t [2:0][2:0]   window_t;

    localparam pixel_t MAG_MAX = 8'd255;

    // Zero-extend a pixel into the signed gradient domain.
    function automatic grad_t to_grad(input pixel_t p);
        return grad_t'({3'b000, p});
    endfunction

    // Absolute value of a gradient; the most negative reachable value is -1020, so negation is safe.
    function automatic mag_t abs_grad(input grad_t g);
        grad_t pos;
        pos = g[10] ? -g : g;
        return mag_t'(pos);
    endfunction

    // |gx| + |gy| of the window, clamped to the 8-bit output range.
    function automatic pixel_t sobel_mag(input window_t w);
        grad_t gx;
        grad_t gy;
        mag_t  m;
        gx = (to_grad(w[0][2]) + (to_grad(w[1][2]) <<< 1) + to_grad(w[2][2]))
           - (to_grad(w[0][0]) + (to_grad(w[1][0]) <<< 1) + to_grad(w[2][0]));
        gy = (to_grad(w[2][0]) + (to_grad(w[2][1]) <<< 1) + to_grad(w[2][2]))
           - (to_grad(w[0][0]) + (to_grad(w[0][1]) <<< 1) + to_grad(w[0][2]));
        m  = abs_grad(gx) + abs_grad(gy);
        return (m > mag_t'(MAG_MAX)) ? MAG_MAX : m[7:0];
    endfunction

endpackage

// File: rtl/sobel_stage_line_buffer.sv
// One-row line buffer: asynchronous read of the old entry, registered write of the new one.
module line_buffer #(
    parameter int DEPTH = 720,
    parameter int DW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_raddr];

    // Registered write of the shifted row data.
    // NOTE: the array has no reset; stale contents only feed rows that never produce output.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/sobel_stage.sv
// Streaming 3x3 Sobel magnitude stage between two FWFT FIFOs: accept stage plus one result register.
module sobel_stage
    import sobel_pkg::*;
#(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 720
) (
    input  logic       clk,
    input  logic       rst,
    output logic       in_rd_en,
    input  logic [7:0] in_dout,
    input  logic       in_empty,
    output logic       out_wr_en,
    output logic [7:0] out_din,
    input  logic       out_full
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    window_t       r_win;
    window_t       w_win_next;
    logic          r_s2_valid;
    pixel_t        r_s2_data;
    logic [15:0]   w_lb_rd;
    pixel_t        w_lb0;
    pixel_t        w_lb1;
    logic          w_load;

    // Pop only when the result register can take a new value this cycle; gated off during reset.
    assign in_rd_en  = !rst && !in_empty && (!r_s2_valid || !out_full);
    assign out_wr_en = !rst && r_s2_valid && !out_full;
    assign out_din   = r_s2_data;
    assign w_load    = in_rd_en && (r_row >= RW'(2));

    // Upper byte is row r-2, lower byte row r-1; one write shifts the column down a row.
    line_buffer #(
        .DEPTH (WIDTH),
        .DW    (16),
        .AW    (CW)
    ) u_lb (
        .clk     (clk),
        .i_we    (in_rd_en),
        .i_waddr (r_col),
        .i_wdata ({w_lb0, in_dout}),
        .i_raddr (r_col),
        .o_rdata (w_lb_rd)
    );

    assign {w_lb1, w_lb0} = w_lb_rd;

    // Window after shifting left and appending the column {row r-2, row r-1, incoming pixel}.
    // NOTE: assigning a default first keeps every path covered, so no latch is inferred.
    always_comb begin
        w_win_next = r_win;
        for (int y = 0; y < 3; y++) begin
            w_win_next[y][0] = r_win[y][1];
            w_win_next[y][1] = r_win[y][2];
        end
        w_win_next[0][2] = w_lb1;
        w_win_next[1][2] = w_lb0;
        w_win_next[2][2] = in_dout;
    end

    // Column/row position of the next pixel to be accepted, wrapping per row and per frame.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_rd_en) begin
            if (r_col == CW'(WIDTH - 1)) begin
                r_col <= '0;
                r_row <= (r_row == RW'(HEIGHT - 1)) ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // Sliding window advances on every accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win <= '0;
        end else if (in_rd_en) begin
            r_win <= w_win_next;
        end
    end

    // Result register: load on accepts from row 2 on, clear once drained with nothing new behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_load) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= (r_col >= CW'(2)) ? sobel_mag(w_win_next) : '0;
        end else if (out_wr_en) begin
            r_s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_stage.sv
// Self-checking bench for sobel_stage: two instances (8x4 and 8x5 frames) checked every cycle
// against an image-level reference model, plus literal expectations for the directed patterns.
`timescale 1ns/1ps
module tb_sobel_stage;

    localparam int W  = 8;
    localparam int H0 = 4;
    localparam int H1 = 5;

    logic       clk = 1'b0;
    logic       rst_s [2];
    logic       rd    [2];
    logic       empty [2];
    logic       wr    [2];
    logic       full  [2];
    logic [7:0] dout  [2];
    logic [7:0] din   [2];

    always #5 clk = ~clk;

    sobel_stage #(.WIDTH(W), .HEIGHT(H0)) dut0 (
        .clk(clk), .rst(rst_s[0]), .in_rd_en(rd[0]), .in_dout(dout[0]), .in_empty(empty[0]),
        .out_wr_en(wr[0]), .out_din(din[0]), .out_full(full[0])
    );

    sobel_stage #(.WIDTH(W), .HEIGHT(H1)) dut1 (
        .clk(clk), .rst(rst_s[1]), .in_rd_en(rd[1]), .in_dout(dout[1]), .in_empty(empty[1]),
        .out_wr_en(wr[1]), .out_din(din[1]), .out_full(full[1])
    );

    int checks = 0;
    int errors = 0;

    // Model state: stored image, next pixel position, pending results per instance.
    int img  [2][H1][W];
    int mrow [2];
    int mcol [2];
    int n_acc[2];
    bit acc  [2];
    int q0[$];
    int q1[$];
    int olog[$];

    // Upstream FIFO contents and stimulus controls for the active instance.
    int src[$];
    int act       = 0;
    bit bubbles   = 1'b0;
    int full_mode = 0;
    int cyc       = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic q_push(input int k, input int v);
        if (k == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    function automatic int q_pop(input int k);
        return (k == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    task automatic q_clear(input int k);
        if (k == 0) q0.delete(); else q1.delete();
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Sobel magnitude of the 3x3 neighbourhood whose bottom-right pixel is (r,c).
    function automatic int ref_mag(input int k, input int r, input int c);
        int gx, gy, m;
        gx = (img[k][r-2][c]   + 2*img[k][r-1][c]   + img[k][r][c])
           - (img[k][r-2][c-2] + 2*img[k][r-1][c-2] + img[k][r][c-2]);
        gy = (img[k][r][c-2]   + 2*img[k][r][c-1]   + img[k][r][c])
           - (img[k][r-2][c-2] + 2*img[k][r-2][c-1] + img[k][r-2][c]);
        m = iabs(gx) + iabs(gy);
        return (m > 255) ? 255 : m;
    endfunction

    // Per-cycle comparison for one instance, evaluated on the falling edge.
    task automatic eval(input int k);
        int  hk;
        bit  exp_rd, exp_wr;
        int  v;
        hk     = (k == 0) ? H0 : H1;
        acc[k] = 1'b0;
        if (rst_s[k] === 1'b1) begin
            check("rd_in_reset", rd[k], 0);
            check("wr_in_reset", wr[k], 0);
            q_clear(k);
            mrow[k] = 0;
            mcol[k] = 0;
            return;
        end
        exp_wr = (qsize(k) > 0) && !full[k];
        exp_rd = !empty[k] && ((qsize(k) == 0) || !full[k]);
        check("out_wr_en", wr[k], exp_wr);
        check("in_rd_en", rd[k], exp_rd);
        if (wr[k] === 1'b1) begin
            olog.push_back(int'(din[k]));
            if (qsize(k) > 0) begin
                v = q_pop(k);
                check("out_din", din[k], v);
            end
        end
        if (rd[k] === 1'b1) begin
            acc[k] = 1'b1;
            n_acc[k]++;
            img[k][mrow[k]][mcol[k]] = int'(dout[k]);
            if (mrow[k] >= 2) q_push(k, (mcol[k] >= 2) ? ref_mag(k, mrow[k], mcol[k]) : 0);
            if (mcol[k] == W - 1) begin
                mcol[k] = 0;
                mrow[k] = (mrow[k] == hk - 1) ? 0 : mrow[k] + 1;
            end else begin
                mcol[k]++;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) eval(k);
    end

    // Upstream FIFO / downstream backpressure driver.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (acc[act] && src.size() > 0) void'(src.pop_front());
        for (int k = 0; k < 2; k++) begin
            if (k != act) begin
                empty[k] = 1'b1;
                full[k]  = 1'b0;
            end
        end
        empty[act] = (src.size() == 0) || (bubbles && $urandom_range(3) == 0);
        dout[act]  = (src.size() > 0) ? 8'(src[0]) : 8'h00;
        case (full_mode)
            1:       full[act] = ((cyc % 5) < 3);
            2:       full[act] = ($urandom_range(2) == 0);
            default: full[act] = 1'b0;
        endcase
    end

    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            1:       return 100;
            2:       return (c < 4) ? 0 : 255;
            3:       return (r < 2) ? 0 : 10;
            default: return int'($urandom_range(255));
        endcase
    endfunction

    task automatic load(input int pat, input int h);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < W; c++)
                src.push_back(pix(pat, r, c));
    endtask

    task automatic drain(input int k);
        int t = 0;
        while ((src.size() > 0 || qsize(k) > 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 3000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: instance %0d still busy, src=%0d pending=%0d", k, src.size(), qsize(k));
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic check_p2(input string tag);
        int tbl[8];
        tbl = '{0, 0, 0, 0, 255, 255, 0, 0};
        check({tag, "_count"}, olog.size(), 16);
        foreach (olog[i]) check({tag, "_val"}, olog[i], tbl[i % 8]);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b1;
            empty[k] = 1'b1;
            full[k]  = 1'b0;
            dout[k]  = 8'h00;
        end
        repeat (2) @(posedge clk);
        #2;
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_rd", rd[k], 0);
            check("reset_wr", wr[k], 0);
            check("reset_din", din[k], 0);
        end

        // Flat frame: no edges anywhere.
        @(posedge clk); #2;
        olog.delete();
        load(1, H0);
        drain(0);
        check("p1_count", olog.size(), 16);
        foreach (olog[i]) check("p1_val", olog[i], 0);

        // Vertical step edge: saturating gx in the two columns straddling it.
        olog.delete();
        load(2, H0);
        drain(0);
        check_p2("p2");

        // Horizontal step on the taller instance.
        #2;
        act = 1;
        olog.delete();
        load(3, H1);
        drain(1);
        check("p3_count", olog.size(), 24);
        foreach (olog[i]) check("p3_val", olog[i], ((i % 8) >= 2 && (i / 8) < 2) ? 40 : 0);

        // Flat frame under periodic backpressure.
        #2;
        act = 0;
        full_mode = 1;
        olog.delete();
        load(1, H0);
        drain(0);
        full_mode = 0;
        check("p4_count", olog.size(), 16);
        foreach (olog[i]) check("p4_val", olog[i], 0);

        // Reset after 13 accepts, then a complete frame.
        begin
            int base, t;
            base = n_acc[0];
            t    = 0;
            load(2, H0);
            while (n_acc[0] - base < 13 && t < 500) begin
                @(posedge clk);
                t++;
            end
            check("p5_accepts_before_reset", n_acc[0] - base, 13);
            #2;
            rst_s[0] = 1'b1;
            src.delete();
            @(posedge clk);
            #2;
            rst_s[0] = 1'b0;
            @(negedge clk);
            check("wr_after_reset", wr[0], 0);
            check("din_after_reset", din[0], 0);
            olog.delete();
            load(2, H0);
            drain(0);
            check_p2("p5");
        end

        // Random pixels, bubbles and backpressure on both instances.
        bubbles   = 1'b1;
        full_mode = 2;
        load(0, H0);
        load(0, H0);
        drain(0);
        #2;
        act = 1;
        load(0, H1);
        load(0, H1);
        drain(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
